// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
package inst_rom_loader_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned LD_BYTE_W       = 8;
  localparam int unsigned LD_LANES        = INST_BUS_W / LD_BYTE_W;
  localparam int unsigned LD_CNT_W        = 2;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;
  typedef logic [INST_BUS_W-1:0]      inst_t;
  typedef logic [LD_BYTE_W-1:0]       ld_byte_t;

  localparam inst_t ZERO_WORD = '0;

  // Loader FSM encodings.
  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-serial program-load port of the instruction ROM loader.
interface inst_rom_loader_if
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic              rom_ce;
  inst_addr_t        rom_addr;
  inst_t             rom_data;
  logic              load_en;
  logic              ld_valid;
  ld_byte_t          ld_byte;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_wptr;
  logic              ld_wrap;
  inst_t             ld_csum;

  // Core / host side.
  modport master (
    output rom_ce, rom_addr, load_en, ld_valid, ld_byte,
    input  rom_data, ld_ready, ld_wptr, ld_wrap, ld_csum
  );

  // Memory / loader side.
  modport slave (
    input  rom_ce, rom_addr, load_en, ld_valid, ld_byte,
    output rom_data, ld_ready, ld_wptr, ld_wrap, ld_csum
  );

endinterface

// File: rtl/inst_rom_loader_ld_byte_pack.sv
// Byte lane counter and little-endian 32-bit word assembler.
module inst_rom_loader_ld_byte_pack
  import inst_rom_loader_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     accept,
  input  ld_byte_t byte_in,
  output logic     last_c,
  output logic     word_valid,
  output inst_t    word
);

  logic [LD_CNT_W-1:0] cnt_q;

  // Current accept completes the word.
  assign last_c = accept && (cnt_q == LD_CNT_W'(LD_LANES - 1));

  // Lane fill; word_valid flags a complete word for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_q      <= '0;
      word       <= ZERO_WORD;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_c && !clear;
      if (clear) begin
        cnt_q <= '0;
        word  <= ZERO_WORD;
      end else if (accept) begin
        word[{cnt_q, 3'b000} +: LD_BYTE_W] <= byte_in;
        cnt_q                              <= cnt_q + LD_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with combinational fetch port and byte-serial program loader.
// Optional running XOR checksum of written words: define INST_ROM_CSUM_EN.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  ld_state_e         state_q;
  ld_state_e         state_d;
  logic              pack_clear_c;
  logic              accept_c;
  logic              last_c;
  logic              mem_we_c;
  logic              word_valid;
  inst_t             word;
  logic              ld_ready_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              wrap_q;
  inst_t             mem [DEPTH];
  logic              unused_addr_bits;

  assign accept_c = bus.ld_valid && ld_ready_q;

  inst_rom_loader_ld_byte_pack u_ld_byte_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_c),
    .accept     (accept_c),
    .byte_in    (bus.ld_byte),
    .last_c     (last_c),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, packer clear and memory write strobe.
  always_comb begin
    state_d      = state_q;
    pack_clear_c = 1'b0;
    mem_we_c     = 1'b0;
    case (state_q)
      LD_IDLE: begin
        pack_clear_c = 1'b1;
        if (bus.load_en) state_d = LD_COLLECT;
      end
      LD_COLLECT: begin
        if (!bus.load_en) begin
          state_d      = LD_IDLE;
          pack_clear_c = 1'b1;
        end else if (last_c) begin
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        mem_we_c = word_valid;
        if (bus.load_en) begin
          state_d = LD_COLLECT;
        end else begin
          state_d      = LD_IDLE;
          pack_clear_c = 1'b1;
        end
      end
      default: begin
        state_d      = LD_IDLE;
        pack_clear_c = 1'b1;
      end
    endcase
  end

  // Registered ready, write pointer and sticky wrap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ld_ready_q <= 1'b0;
      wptr_q     <= '0;
      wrap_q     <= 1'b0;
    end else begin
      ld_ready_q <= (state_d == LD_COLLECT);
      if (mem_we_c) begin
        wptr_q <= wptr_q + ADDR_W'(1);
        if (wptr_q == ADDR_W'(DEPTH - 1)) wrap_q <= 1'b1;
      end
    end
  end

`ifdef INST_ROM_CSUM_EN
  inst_t csum_q;

  // Running XOR of every word committed to memory.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      csum_q <= ZERO_WORD;
    end else if (mem_we_c) begin
      csum_q <= csum_q ^ word;
    end
  end

  assign bus.ld_csum = csum_q;
`else
  assign bus.ld_csum = ZERO_WORD;
`endif

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wptr_q] <= word;
  end

  // Zero-latency fetch, blanked to NOP while loading or disabled.
  always_comb begin
    bus.rom_data = ZERO_WORD;
    if ((bus.rom_ce == CHIP_ENABLE) && !bus.load_en) begin
      bus.rom_data = mem[bus.rom_addr[ADDR_W+1:2]];
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_wptr  = wptr_q;
  assign bus.ld_wrap  = wrap_q;

  // Byte offset and aliased high address bits are intentionally ignored.
  assign unused_addr_bits = ^{bus.rom_addr[INST_ADDR_BUS_W-1:ADDR_W+2], bus.rom_addr[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader with a queue-based reference model.
module tb_inst_rom_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   fetch_noise;

  inst_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: memory image, write pointer, wrap, checksum, collected bytes.
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  int          m_wptr;
  bit          m_wrap;
  logic [31:0] m_csum;
  logic [7:0]  m_q [$];
  bit          m_pend;
  logic [31:0] m_pword;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, then advance the model across the coming clock edge.
  always @(negedge clk) begin
    logic [31:0] exp_data;
    logic [31:0] exp_csum;
    int          idx;
    if (!rst) begin
      m_wptr = 0;
      m_wrap = 0;
      m_csum = 32'h0;
      m_pend = 0;
      m_q.delete();
      chk("rst_ready", 32'(bus.ld_ready), 32'h0);
      chk("rst_wptr",  32'(bus.ld_wptr),  32'h0);
      chk("rst_wrap",  32'(bus.ld_wrap),  32'h0);
      chk("rst_csum",  bus.ld_csum,       32'h0);
    end else begin
      idx = int'(bus.rom_addr[ADDR_W+1:2]);
      if (bus.rom_ce && !bus.load_en) begin
        if (m_vld[idx]) chk("fetch", bus.rom_data, m_mem[idx]);
      end else begin
        chk("fetch_nop", bus.rom_data, 32'h0);
      end
`ifdef INST_ROM_CSUM_EN
      exp_csum = m_csum;
`else
      exp_csum = 32'h0;
`endif
      chk("wptr", 32'(bus.ld_wptr), 32'(m_wptr));
      chk("wrap", 32'(bus.ld_wrap), 32'(m_wrap));
      chk("csum", bus.ld_csum, exp_csum);
      exp_data = 32'h0;
      if (m_pend) begin
        m_mem[m_wptr] = m_pword;
        m_vld[m_wptr] = 1'b1;
        m_csum        = m_csum ^ m_pword;
        if (m_wptr == DEPTH - 1) m_wrap = 1;
        m_wptr = (m_wptr + 1) % DEPTH;
        m_pend = 0;
      end
      if (!bus.load_en) begin
        m_q.delete();
      end else if (bus.ld_valid && bus.ld_ready) begin
        m_q.push_back(bus.ld_byte);
        if (m_q.size() == 4) begin
          m_pword = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_pend  = 1;
          m_q.delete();
        end
      end
    end
  end

  // Random fetch traffic when enabled.
  always @(posedge clk) begin
    #1;
    if (fetch_noise) begin
      bus.rom_ce   = 1'($urandom);
      bus.rom_addr = 32'($urandom);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'($urandom);
        idle(1);
      end
    end
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    got = 0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = bus.ld_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.ld_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_byte: ld_ready never seen high, byte %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    fetch_noise  = 0;
    rst          = 1'b0;
    bus.rom_ce   = 1'b0;
    bus.rom_addr = 32'h0;
    bus.load_en  = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = 8'h0;
    idle(3);
    rst = 1'b1;
    idle(1);
    chk("init_ready", 32'(bus.ld_ready), 32'h0);
    chk("init_wptr",  32'(bus.ld_wptr),  32'h0);

    // First word, ready drops for exactly one cycle after the 4th byte.
    bus.load_en = 1'b1;
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h34, 0);
    chk("write_ready_low", 32'(bus.ld_ready), 32'h0);
    chk("write_wptr_old",  32'(bus.ld_wptr),  32'h0);
    idle(1);
    chk("after_ready_high", 32'(bus.ld_ready), 32'h1);
    chk("after_wptr",       32'(bus.ld_wptr),  32'h1);

    // Fetch with byte offset, disable and aliasing.
    bus.load_en  = 1'b0;
    bus.rom_ce   = 1'b1;
    bus.rom_addr = 32'h0;
    #1 chk("fetch_a0", bus.rom_data, 32'h34010013);
    bus.rom_addr = 32'h2;
    #1 chk("fetch_a2", bus.rom_data, 32'h34010013);
    bus.rom_ce   = 1'b0;
    #1 chk("fetch_ce0", bus.rom_data, 32'h0);
    bus.rom_ce   = 1'b1;
    bus.rom_addr = 32'(4 << ADDR_W);
    #1 chk("fetch_alias", bus.rom_data, 32'h34010013);

    // Abandoned partial word, then clean next word.
    bus.load_en = 1'b1;
    send_byte(8'hEE, 0);
    send_byte(8'h77, 0);
    bus.load_en = 1'b0;
    idle(3);
    chk("partial_wptr", 32'(bus.ld_wptr), 32'h1);
    bus.load_en = 1'b1;
    send_word(32'hAABBCCDD, 0);
    idle(2);
    bus.load_en  = 1'b0;
    bus.rom_addr = 32'h4;
    #1 chk("fetch_w1", bus.rom_data, 32'hAABBCCDD);
    chk("w1_wptr", 32'(bus.ld_wptr), 32'h2);

    // Asynchronous reset mid-word.
    bus.load_en = 1'b1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #1 rst = 1'b0;
    #1 chk("async_ready", 32'(bus.ld_ready), 32'h0);
    chk("async_wptr", 32'(bus.ld_wptr), 32'h0);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    bus.rom_addr = 32'h0;
    #1 chk("keep_w0", bus.rom_data, 32'h34010013);
    bus.rom_addr = 32'h4;
    #1 chk("keep_w1", bus.rom_data, 32'hAABBCCDD);

    // Checksum of two complementary words, random gaps.
    bus.load_en = 1'b1;
    send_word(32'h0000FFFF, 1);
    send_word(32'hFFFF0000, 1);
    idle(2);
    bus.load_en = 1'b0;
    idle(1);
`ifdef INST_ROM_CSUM_EN
    chk("csum_lit", bus.ld_csum, 32'hFFFFFFFF);
`else
    chk("csum_lit", bus.ld_csum, 32'h0);
`endif
    chk("csum_wptr", 32'(bus.ld_wptr), 32'h2);
    bus.rom_addr = 32'h0;
    #1 chk("fetch_cs0", bus.rom_data, 32'h0000FFFF);

    // Fill DEPTH+1 words with gaps and fetch noise: pointer wraps.
    pulse_reset();
    fetch_noise = 1;
    bus.load_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) send_word(32'hC0DE0000 | 32'(i), 1);
    idle(2);
    bus.load_en = 1'b0;
    fetch_noise = 0;
    idle(1);
    chk("wrap_wptr", 32'(bus.ld_wptr), 32'h1);
    chk("wrap_flag", 32'(bus.ld_wrap), 32'h1);
    bus.rom_ce   = 1'b1;
    bus.rom_addr = 32'h0;
    #1 chk("wrap_w0", bus.rom_data, 32'hC0DE0400);
    bus.rom_addr = 32'h4;
    #1 chk("wrap_w1", bus.rom_data, 32'hC0DE0001);
    bus.rom_addr = 32'(4 * (DEPTH - 1));
    #1 chk("wrap_wlast", bus.rom_data, 32'hC0DE03FF);

    // Random fetch sweep against the model image.
    fetch_noise = 1;
    idle(300);
    fetch_noise = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
